// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter
//   Shares the single RegBank write port (we3/A3/WD3) between two requesters:
//   requester 0 (writeback path) and requester 1 (debug/test loader).
//   Round-robin arbitration with a req/ack handshake. The issue is registered
//   one cycle after the request is sampled.
//
//   Optional build macro: REGBANK_ZERO_GUARD_EN
//     defined     - a granted write to address 0 is acked and arbitrated as
//                   usual, but we3 stays low because x0 is hardwired.
//     not defined - address 0 is written like any other register.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no write issued this cycle; we3=0, A3/WD3 keep their last values
//   WR0   | issuing requester 0's write; wr_ack0=1
//   WR1   | issuing requester 1's write; wr_ack1=1

module regbank_write_arbiter #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 5
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             wr_req0,
    input  logic [SIZE-1:0]  wr_addr0,
    input  logic [WIDTH-1:0] wr_data0,
    output logic             wr_ack0,

    input  logic             wr_req1,
    input  logic [SIZE-1:0]  wr_addr1,
    input  logic [WIDTH-1:0] wr_data1,
    output logic             wr_ack1,

    output logic             we3,
    output logic [SIZE-1:0]  A3,
    output logic [WIDTH-1:0] WD3,
    output logic             last_grant
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WR0  = 2'b01,
        WR1  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant_nxt;

    logic             elig0;
    logic             elig1;
    logic             grant_vld;
    logic             grant_id;
    logic [SIZE-1:0]  sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic             we_nxt;

    // A requester being acked this cycle already has its write on the port;
    // masking it here keeps a held req from being written twice.
    assign elig0 = wr_req0 & (state != WR0);
    assign elig1 = wr_req1 & (state != WR1);

    // State register and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Grant selection: on contention the requester that was not granted last wins.
    always_comb begin
        state_nxt      = IDLE;
        last_grant_nxt = last_grant;
        grant_vld      = 1'b0;
        grant_id       = 1'b0;
        sel_addr       = wr_addr0;
        sel_data       = wr_data0;

        case ({elig1, elig0})
            2'b11: begin
                grant_vld = 1'b1;
                grant_id  = ~last_grant;
            end
            2'b01: begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end
            2'b10: begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
            default: begin
                grant_vld = 1'b0;
                grant_id  = 1'b0;
            end
        endcase

        if (grant_vld) begin
            last_grant_nxt = grant_id;
            if (grant_id) begin
                state_nxt = WR1;
                sel_addr  = wr_addr1;
                sel_data  = wr_data1;
            end else begin
                state_nxt = WR0;
                sel_addr  = wr_addr0;
                sel_data  = wr_data0;
            end
        end
    end

    // Write enable for the next cycle; with the zero guard, x0 is never written.
    always_comb begin
`ifdef REGBANK_ZERO_GUARD_EN
        we_nxt = grant_vld & (sel_addr != '0);
`else
        we_nxt = grant_vld;
`endif
    end

    // Registered RegBank port and acks; address/data hold while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we3     <= 1'b0;
            A3      <= '0;
            WD3     <= '0;
            wr_ack0 <= 1'b0;
            wr_ack1 <= 1'b0;
        end else begin
            we3     <= we_nxt;
            wr_ack0 <= grant_vld & ~grant_id;
            wr_ack1 <= grant_vld &  grant_id;
            if (grant_vld) begin
                A3  <= sel_addr;
                WD3 <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb_regbank_write_arbiter
//   Self-checking bench for regbank_write_arbiter. A behavioural model tracks
//   which requester holds the port each cycle, the round-robin pointer and
//   the register bank contents; DUT outputs are compared against it.
//   Honours REGBANK_ZERO_GUARD_EN when the same macro is defined for the build.

module tb_regbank_write_arbiter;

    localparam int WIDTH = 32;
    localparam int SIZE  = 5;
    localparam int NREG  = 1 << SIZE;
    localparam int PW    = 1 + SIZE + WIDTH + 3;

    logic             clk;
    logic             reset_n;
    logic             wr_req0;
    logic [SIZE-1:0]  wr_addr0;
    logic [WIDTH-1:0] wr_data0;
    logic             wr_ack0;
    logic             wr_req1;
    logic [SIZE-1:0]  wr_addr1;
    logic [WIDTH-1:0] wr_data1;
    logic             wr_ack1;
    logic             we3;
    logic [SIZE-1:0]  A3;
    logic [WIDTH-1:0] WD3;
    logic             last_grant;

    int checks = 0;
    int errors = 0;

    regbank_write_arbiter #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_req0    (wr_req0),
        .wr_addr0   (wr_addr0),
        .wr_data0   (wr_data0),
        .wr_ack0    (wr_ack0),
        .wr_req1    (wr_req1),
        .wr_addr1   (wr_addr1),
        .wr_data1   (wr_data1),
        .wr_ack1    (wr_ack1),
        .we3        (we3),
        .A3         (A3),
        .WD3        (WD3),
        .last_grant (last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    int               m_owner;   // requester holding the port this cycle, -1 = none
    bit               m_lg;
    bit               m_we3;
    logic [SIZE-1:0]  m_a3;
    logic [WIDTH-1:0] m_wd3;
    bit               m_ack0;
    bit               m_ack1;
    logic [WIDTH-1:0] m_bank   [NREG];
    logic [WIDTH-1:0] obs_bank [NREG];

`ifdef REGBANK_ZERO_GUARD_EN
    localparam bit ZERO_GUARD = 1'b1;
`else
    localparam bit ZERO_GUARD = 1'b0;
`endif

    function automatic void model_reset();
        m_owner = -1;
        m_lg    = 1'b1;
        m_we3   = 1'b0;
        m_a3    = '0;
        m_wd3   = '0;
        m_ack0  = 1'b0;
        m_ack1  = 1'b0;
    endfunction

    // One clock edge: whoever wants the port and is not already on it competes;
    // ties go to the one not served most recently.
    function automatic void model_edge();
        bit want0 = wr_req0 && (m_owner != 0);
        bit want1 = wr_req1 && (m_owner != 1);
        int g = -1;
        if (want0 && want1) g = (m_lg == 1'b1) ? 0 : 1;
        else if (want0)     g = 0;
        else if (want1)     g = 1;
        m_owner = g;
        m_ack0  = (g == 0);
        m_ack1  = (g == 1);
        if (g < 0) begin
            m_we3 = 1'b0;
        end else begin
            m_lg  = (g == 1);
            m_a3  = (g == 0) ? wr_addr0 : wr_addr1;
            m_wd3 = (g == 0) ? wr_data0 : wr_data1;
            m_we3 = !(ZERO_GUARD && m_a3 == 0);
            if (m_we3) m_bank[m_a3] = m_wd3;
        end
    endfunction

    function automatic logic [PW-1:0] dut_vec();
        return {we3, A3, WD3, wr_ack0, wr_ack1, last_grant};
    endfunction

    function automatic logic [PW-1:0] model_vec();
        return {m_we3, m_a3, m_wd3, m_ack0, m_ack1, m_lg};
    endfunction

    // Advance one cycle; afterwards we are at the falling edge, outputs settled.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (we3 === 1'b1) obs_bank[A3] = WD3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        wr_req0 = 0; wr_req1 = 0;
        wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_bank[i]   = '0;
            obs_bank[i] = '0;
        end
        #12;
        checks++;
        if (dut_vec() !== {1'b0, {SIZE{1'b0}}, {WIDTH{1'b0}}, 3'b001}) begin
            errors++;
            $display("FAIL reset_values got %h expected %h", dut_vec(),
                     {1'b0, {SIZE{1'b0}}, {WIDTH{1'b0}}, 3'b001});
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL reset_idle got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_reset_mid_write();
        wr_req0 = 1; wr_addr0 = 5'd3; wr_data0 = $urandom;
        step();
        checks++;
        if ({we3, wr_ack0} !== 2'b11 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL midwr_issue got %h expected %h", dut_vec(), model_vec());
        end
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({we3, wr_ack0, wr_ack1, last_grant} !== 4'b0001) begin
            errors++;
            $display("FAIL midwr_async_reset got %b expected 0001",
                     {we3, wr_ack0, wr_ack1, last_grant});
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        checks++;
        if ({we3, wr_ack0, A3} !== {2'b11, 5'd3} || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL midwr_reissue got %h expected %h", dut_vec(), model_vec());
        end
        wr_req0 = 0;
        step();
    endtask

    task automatic test_single_held();
        bit exp_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        wr_req0 = 1; wr_addr0 = 5'd5; wr_data0 = 32'hDEADBEEF;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if ({we3, wr_ack0, wr_ack1} !== {exp_pat[c], exp_pat[c], 1'b0}
                || A3 !== 5'd5 || WD3 !== 32'hDEADBEEF
                || dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL single_held cyc%0d got %h expected %h",
                         c + 1, dut_vec(), model_vec());
            end
        end
        wr_req0 = 0;
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        wr_req0 = 1; wr_addr0 = 5'd10; wr_data0 = 32'hA0A0_0001;
        wr_req1 = 1; wr_addr1 = 5'd11; wr_data1 = 32'hB0B0_0002;
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if (we3 !== 1'b1 || wr_ack0 !== ((c % 2) == 0) || wr_ack1 !== ((c % 2) == 1)
                || dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL back_to_back cyc%0d got %h expected %h",
                         c + 1, dut_vec(), model_vec());
            end
        end
        wr_req0 = 0; wr_req1 = 0;
        step();
    endtask

    task automatic test_same_addr();
        do_reset();
        wr_req0 = 1; wr_addr0 = 5'd7; wr_data0 = 32'h11;
        wr_req1 = 1; wr_addr1 = 5'd7; wr_data1 = 32'h22;
        step();
        checks++;
        if ({wr_ack0, wr_ack1, WD3} !== {2'b10, 32'h11} || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL same_addr_first got %h expected %h", dut_vec(), model_vec());
        end
        wr_req0 = 0;
        step();
        checks++;
        if ({wr_ack0, wr_ack1, WD3} !== {2'b01, 32'h22} || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL same_addr_second got %h expected %h", dut_vec(), model_vec());
        end
        wr_req1 = 0;
        step();
        checks++;
        if (obs_bank[7] !== 32'h22 || obs_bank[7] !== m_bank[7]) begin
            errors++;
            $display("FAIL same_addr_bank got %h expected %h", obs_bank[7], 32'h22);
        end
    endtask

    task automatic test_zero_addr();
        step();
        wr_req1 = 1; wr_addr1 = '0; wr_data1 = 32'hFF;
        step();
        checks++;
        if ({wr_ack1, we3, A3} !== {1'b1, !ZERO_GUARD, 5'd0} || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL zero_addr got %h expected %h", dut_vec(), model_vec());
        end
        wr_req1 = 0;
        step();
    endtask

    task automatic test_rr_after_solo();
        int acks1 = 0;
        wr_req1 = 1; wr_addr1 = 5'd20; wr_data1 = $urandom;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL solo1 cyc%0d got %h expected %h", c + 1, dut_vec(), model_vec());
            end
            if (wr_ack1 === 1'b1) acks1++;
            if (m_ack1) begin
                wr_addr1 = wr_addr1 + 5'd1;
                wr_data1 = $urandom;
            end
        end
        checks++;
        if (acks1 != 3) begin
            errors++;
            $display("FAIL solo1_count got %0d expected 3", acks1);
        end
        wr_req1 = 0;
        step();
        wr_req0 = 1; wr_addr0 = 5'd25; wr_data0 = $urandom;
        wr_req1 = 1; wr_addr1 = 5'd26; wr_data1 = $urandom;
        step();
        checks++;
        if ({wr_ack0, wr_ack1, last_grant} !== 3'b100 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL rr_after_solo got %h expected %h", dut_vec(), model_vec());
        end
        wr_req0 = 0; wr_req1 = 0;
        step();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 600; c++) begin
            step();
            checks++;
            if (dut_vec() !== model_vec() || (wr_ack0 === 1'b1 && wr_ack1 === 1'b1)) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random cyc%0d got %h expected %h", c, dut_vec(), model_vec());
            end
            if (wr_req0) begin
                if (m_ack0) begin
                    if ($urandom_range(0, 9) < 6) begin
                        wr_addr0 = SIZE'($urandom); wr_data0 = $urandom;
                    end else wr_req0 = 0;
                end else if ($urandom_range(0, 19) == 0) wr_req0 = 0;
            end else if ($urandom_range(0, 9) < 4) begin
                wr_req0 = 1; wr_addr0 = SIZE'($urandom); wr_data0 = $urandom;
            end
            if (wr_req1) begin
                if (m_ack1) begin
                    if ($urandom_range(0, 9) < 6) begin
                        wr_addr1 = SIZE'($urandom); wr_data1 = $urandom;
                    end else wr_req1 = 0;
                end else if ($urandom_range(0, 19) == 0) wr_req1 = 0;
            end else if ($urandom_range(0, 9) < 4) begin
                wr_req1 = 1; wr_addr1 = SIZE'($urandom); wr_data1 = $urandom;
            end
        end
        wr_req0 = 0; wr_req1 = 0;
        step();
        step();
        for (int i = 0; i < NREG; i++) begin
            checks++;
            if (obs_bank[i] !== m_bank[i]) begin
                errors++;
                $display("FAIL bank x%0d got %h expected %h", i, obs_bank[i], m_bank[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_write();
        test_single_held();
        test_back_to_back();
        test_same_addr();
        test_zero_addr();
        test_rr_after_solo();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
